// File: rtl/sp_octet_pkg.sv
// Shared types and geometry for the K-looped 2:4 sparse octet.
package sp_octet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FETCH      = 2'd1,
    ST_COMPUTE    = 2'd2,
    ST_WRITE_BACK = 2'd3
  } state_e;

  localparam int unsigned LANES_PER_TG = 4;
  localparam int unsigned NNZ_PER_LANE = 4;
  localparam int unsigned SPARSE_BLOCK = 4;
  localparam int unsigned IDX_W        = 2;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sp_lane_dot.sv
// One lane of the 2:4 sparse dot: select activations by index, multiply, sum.
module sp_lane_dot
  import sp_octet_pkg::*;
#(
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned ACC_W  = 16
) (
  input  logic [NNZ_PER_LANE*ELEM_W-1:0]   w_i,
  input  logic [NNZ_PER_LANE*IDX_W-1:0]    idx_i,
  input  logic [2*SPARSE_BLOCK*ELEM_W-1:0] act_i,
  output logic [ACC_W-1:0]                 dot_o
);

  logic signed [ELEM_W-1:0] wv;
  logic signed [ELEM_W-1:0] av;
  logic signed [ACC_W-1:0]  prod;
  logic        [IDX_W:0]    sel;
  logic        [ACC_W-1:0]  sum;

  // First half of the nonzeros index activation block 0, second half block 1.
  always_comb begin
    sum  = '0;
    wv   = '0;
    av   = '0;
    prod = '0;
    sel  = '0;
    for (int unsigned n = 0; n < NNZ_PER_LANE; n++) begin
      sel  = {(n >= NNZ_PER_LANE/2) ? 1'b1 : 1'b0, idx_i[n*IDX_W +: IDX_W]};
      wv   = w_i[n*ELEM_W +: ELEM_W];
      av   = act_i[sel*ELEM_W +: ELEM_W];
      prod = ACC_W'(wv) * ACC_W'(av);
      sum  = sum + prod;
    end
    dot_o = sum;
  end

endmodule

// File: rtl/sp_octet_kloop.sv
// Sparse octet accumulating K_STEPS buffered operand beats per operation,
// with valid/ready operand fetch and result streams.
module sp_octet_kloop
  import sp_octet_pkg::*;
#(
  parameter int unsigned NUM_TG  = 2,
  parameter int unsigned ELEM_W  = 8,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned K_STEPS = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [LANES_PER_TG*NUM_TG*ACC_W-1:0]          c_data_in,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [LANES_PER_TG*NUM_TG*4*ELEM_W-1:0]       a_data_in,
  input  logic [LANES_PER_TG*NUM_TG*8-1:0]              idx_in,
  input  logic [8*ELEM_W-1:0]                           b_data_in,
  output logic                                          idle,
  output logic                                          fetch,
  output logic                                          compute,
  output logic                                          write_back,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [LANES_PER_TG*NUM_TG*ACC_W-1:0]          result_out
);

  localparam int unsigned NUM_LANES = LANES_PER_TG * NUM_TG;
  localparam int unsigned A_W       = NNZ_PER_LANE * ELEM_W;
  localparam int unsigned IX_W      = NNZ_PER_LANE * IDX_W;
  localparam int unsigned B_W       = 2 * SPARSE_BLOCK * ELEM_W;
  localparam int unsigned PTR_W     = ptr_width(K_STEPS);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(K_STEPS - 1);

  state_e                      state_q;
  logic [PTR_W-1:0]            wr_ptr_q;
  logic [PTR_W-1:0]            rd_ptr_q;
  logic [NUM_LANES*A_W-1:0]    a_buf_q   [K_STEPS];
  logic [NUM_LANES*IX_W-1:0]   idx_buf_q [K_STEPS];
  logic [B_W-1:0]              b_buf_q   [K_STEPS];
  logic [ACC_W-1:0]            acc_q     [NUM_LANES];
  logic [ACC_W-1:0]            acc_d     [NUM_LANES];
  logic [ACC_W-1:0]            dot       [NUM_LANES];
  logic [NUM_LANES*ACC_W-1:0]  acc_flat;
  logic [NUM_LANES*A_W-1:0]    a_rd;
  logic [NUM_LANES*IX_W-1:0]   idx_rd;
  logic [B_W-1:0]              b_rd;

  assign a_rd   = a_buf_q[rd_ptr_q];
  assign idx_rd = idx_buf_q[rd_ptr_q];
  assign b_rd   = b_buf_q[rd_ptr_q];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    sp_lane_dot #(
      .ELEM_W (ELEM_W),
      .ACC_W  (ACC_W)
    ) u_dot (
      .w_i   (a_rd[l*A_W +: A_W]),
      .idx_i (idx_rd[l*IX_W +: IX_W]),
      .act_i (b_rd),
      .dot_o (dot[l])
    );
  end

  always_comb begin
    acc_flat = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      acc_d[l]                       = acc_q[l] + dot[l];
      acc_flat[l*ACC_W +: ACC_W]     = acc_q[l];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned k = 0; k < K_STEPS; k++) begin
        a_buf_q[k]   <= '0;
        idx_buf_q[k] <= '0;
        b_buf_q[k]   <= '0;
      end
      for (int unsigned l = 0; l < NUM_LANES; l++) acc_q[l] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            for (int unsigned l = 0; l < NUM_LANES; l++)
              acc_q[l] <= c_data_in[l*ACC_W +: ACC_W];
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (in_valid) begin
            a_buf_q[wr_ptr_q]   <= a_data_in;
            idx_buf_q[wr_ptr_q] <= idx_in;
            b_buf_q[wr_ptr_q]   <= b_data_in;
            if (wr_ptr_q == LAST) state_q <= ST_COMPUTE;
            else                  wr_ptr_q <= wr_ptr_q + 1'b1;
          end
        end
        ST_COMPUTE: begin
          for (int unsigned l = 0; l < NUM_LANES; l++) acc_q[l] <= acc_d[l];
          if (rd_ptr_q == LAST) state_q <= ST_WRITE_BACK;
          else                  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        ST_WRITE_BACK: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign idle       = (state_q == ST_IDLE);
  assign fetch      = (state_q == ST_FETCH);
  assign compute    = (state_q == ST_COMPUTE);
  assign write_back = (state_q == ST_WRITE_BACK);
  assign in_ready   = fetch;
  assign out_valid  = write_back;
  assign result_out = out_valid ? acc_flat : '0;

endmodule

// File: tb/tb_sp_octet_kloop.sv
// Directed self-checking bench for sp_octet_kloop at default parameters.
module tb_sp_octet_kloop;

  localparam int NL = 8;
  localparam int AW = NL * 32;
  localparam int IW = NL * 8;
  localparam int BW = 64;
  localparam int CW = NL * 16;

  logic          clk, rst, start, in_valid, in_ready, out_valid, out_ready;
  logic          idle, fetch, compute, write_back;
  logic [CW-1:0] c_data_in, result_out;
  logic [AW-1:0] a_data_in;
  logic [IW-1:0] idx_in;
  logic [BW-1:0] b_data_in;

  logic [AW-1:0] beat_a   [4];
  logic [IW-1:0] beat_idx [4];
  logic [BW-1:0] beat_b   [4];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  sp_octet_kloop #(
    .NUM_TG  (2),
    .ELEM_W  (8),
    .ACC_W   (16),
    .K_STEPS (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .c_data_in  (c_data_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_data_in  (a_data_in),
    .idx_in     (idx_in),
    .b_data_in  (b_data_in),
    .idle       (idle),
    .fetch      (fetch),
    .compute    (compute),
    .write_back (write_back),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_out (result_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] rep_a(input int w0, input int w1, input int w2, input int w3);
    logic [AW-1:0] r;
    for (int l = 0; l < NL; l++) r[l*32 +: 32] = {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
    return r;
  endfunction

  function automatic logic [IW-1:0] rep_idx(input int i0, input int i1, input int i2, input int i3);
    logic [IW-1:0] r;
    for (int l = 0; l < NL; l++) r[l*8 +: 8] = {2'(i3), 2'(i2), 2'(i1), 2'(i0)};
    return r;
  endfunction

  function automatic logic [BW-1:0] mk_b(input int a0, input int a1, input int a2, input int a3,
                                         input int a4, input int a5, input int a6, input int a7);
    return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic load_basic();
    for (int k = 0; k < 4; k++) begin
      beat_a[k]   = rep_a(1, 2, 3, 4);
      beat_idx[k] = rep_idx(3, 0, 2, 1);
      beat_b[k]   = mk_b(1, 2, 3, 4, 5, 6, 7, 8);
    end
  endtask

  task automatic do_start(input logic [CW-1:0] c);
    start     = 1;
    c_data_in = c;
    @(posedge clk); #1;
    start     = 0;
    c_data_in = '0;
    cyc       = 1;
  endtask

  // Offers beats following vpat (LSB first, 1 after plen); ok=0 if the budget runs out.
  task automatic feed(input logic [5:0] vpat, input int plen, output bit ok);
    int  k, p;
    logic rdy;
    k = 0;
    p = 0;
    while (k < 4 && p < 40) begin
      in_valid  = (p < plen) ? vpat[p] : 1'b1;
      a_data_in = beat_a[k];
      idx_in    = beat_idx[k];
      b_data_in = beat_b[k];
      rdy       = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (in_valid && rdy) k++;
      p++;
    end
    in_valid = 0;
    ok = (k == 4);
  endtask

  task automatic wait_out(output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      cyc++;
      n++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    rst = 1;
    @(posedge clk); #1;
    vectors++;
    if ({idle, fetch, compute, write_back} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags: got %b expected 1000", {idle, fetch, compute, write_back});
    end
    vectors++;
    if ({in_ready, out_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_handshake: got %b expected 00", {in_ready, out_valid});
    end
    vectors++;
    if (result_out !== '0) begin
      errors++; $display("FAIL reset_result: got %h expected 0", result_out);
    end
    rst = 0;
  endtask

  task automatic test_basic();
    bit ok;
    load_basic();
    do_start('0);
    vectors++;
    if ({idle, fetch, compute, write_back} !== 4'b0100) begin
      errors++; $display("FAIL basic_fetch_flag: got %b expected 0100", {idle, fetch, compute, write_back});
    end
    feed(6'b111111, 6, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL basic_feed_timeout: got 0 expected 1"); end
    wait_out(ok);
    vectors++;
    if (!ok || cyc !== 9) begin
      errors++; $display("FAIL basic_latency: got cycle %0d expected 9", cyc);
    end
    for (int l = 0; l < NL; l++) begin
      vectors++;
      if (result_out[l*16 +: 16] !== 16'h00CC) begin
        errors++; $display("FAIL basic_lane%0d: got %h expected 00cc", l, result_out[l*16 +: 16]);
      end
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    vectors++;
    if ({idle, out_valid, result_out} !== {1'b1, 1'b0, {CW{1'b0}}}) begin
      errors++; $display("FAIL basic_return_idle: got idle=%b ov=%b res=%h expected idle=1 ov=0 res=0",
                         idle, out_valid, result_out);
    end
  endtask

  task automatic test_signed_wrap();
    bit ok;
    for (int k = 0; k < 4; k++) begin
      beat_a[k]   = rep_a(-128, -128, -128, -128);
      beat_idx[k] = rep_idx(0, 1, 2, 3);
      beat_b[k]   = mk_b(127, 127, 127, 127, 127, 127, 127, 127);
    end
    do_start('0);
    feed(6'b111111, 6, ok);
    wait_out(ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL wrap_timeout: got 0 expected 1"); end
    for (int l = 0; l < NL; l++) begin
      vectors++;
      if (result_out[l*16 +: 16] !== 16'h0800) begin
        errors++; $display("FAIL wrap_lane%0d: got %h expected 0800", l, result_out[l*16 +: 16]);
      end
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_preload();
    bit ok;
    logic [CW-1:0] c;
    for (int l = 0; l < NL; l++) c[l*16 +: 16] = 16'(l * 1000);
    for (int k = 0; k < 4; k++) begin
      beat_a[k]   = rep_a(0, 0, 0, 0);
      beat_idx[k] = rep_idx(1, 2, 3, 0);
      beat_b[k]   = mk_b(1, 2, 3, 4, 5, 6, 7, 8);
    end
    do_start(c);
    feed(6'b111111, 6, ok);
    wait_out(ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL preload_timeout: got 0 expected 1"); end
    for (int l = 0; l < NL; l++) begin
      vectors++;
      if (result_out[l*16 +: 16] !== 16'(l * 1000)) begin
        errors++; $display("FAIL preload_lane%0d: got %0d expected %0d", l, result_out[l*16 +: 16], l * 1000);
      end
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    load_basic();
    do_start('0);
    vectors++;
    if (fetch !== 1'b1) begin errors++; $display("FAIL b2b_start_accepted: got %b expected 1", fetch); end
    feed(6'b111111, 6, ok);
    wait_out(ok);
    vectors++;
    if (!ok || cyc !== 9) begin errors++; $display("FAIL b2b_latency: got cycle %0d expected 9", cyc); end
    vectors++;
    if (result_out[7*16 +: 16] !== 16'h00CC) begin
      errors++; $display("FAIL b2b_lane7: got %h expected 00cc", result_out[7*16 +: 16]);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [CW-1:0] snap;
    // Beat k dot = (k+1)^2 + 10 + 2*5, summed over k = 0..3 gives 110.
    for (int k = 0; k < 4; k++) begin
      beat_a[k]   = rep_a(k + 1, 1, 0, 2);
      beat_idx[k] = rep_idx(0, 1, 0, 3);
      beat_b[k]   = mk_b(k + 1, 10, 0, 0, 0, 0, 0, 5);
    end
    do_start('0);
    feed(6'b101101, 6, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL bp_feed_timeout: got 0 expected 1"); end
    wait_out(ok);
    vectors++;
    if (!ok || cyc !== 11) begin errors++; $display("FAIL bp_latency: got cycle %0d expected 11", cyc); end
    for (int l = 0; l < NL; l++) begin
      vectors++;
      if (result_out[l*16 +: 16] !== 16'd110) begin
        errors++; $display("FAIL bp_lane%0d: got %0d expected 110", l, result_out[l*16 +: 16]);
      end
    end
    snap = result_out;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || result_out !== snap) begin
        errors++; $display("FAIL bp_stall%0d: got ov=%b res=%h expected ov=1 res=%h", s, out_valid, result_out, snap);
      end
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    vectors++;
    if (idle !== 1'b1) begin errors++; $display("FAIL bp_release: got idle=%b expected 1", idle); end
  endtask

  task automatic test_ignored_start();
    bit ok;
    load_basic();
    do_start('0);
    feed(6'b111111, 6, ok);
    start     = 1;
    c_data_in = '1;
    @(posedge clk); #1;
    cyc++;
    start     = 0;
    c_data_in = '0;
    vectors++;
    if ({idle, fetch, compute, write_back} !== 4'b0010) begin
      errors++; $display("FAIL ign_start_flags: got %b expected 0010", {idle, fetch, compute, write_back});
    end
    wait_out(ok);
    vectors++;
    if (!ok || cyc !== 9) begin errors++; $display("FAIL ign_start_latency: got cycle %0d expected 9", cyc); end
    vectors++;
    if (result_out[0 +: 16] !== 16'h00CC) begin
      errors++; $display("FAIL ign_start_lane0: got %h expected 00cc", result_out[0 +: 16]);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_midop_reset();
    bit ok;
    load_basic();
    do_start('0);
    feed(6'b111111, 6, ok);
    vectors++;
    if (compute !== 1'b1) begin errors++; $display("FAIL mid_in_compute: got %b expected 1", compute); end
    #1 rst = 1;
    #2;
    vectors++;
    if ({idle, fetch, compute, write_back, in_ready, out_valid} !== 6'b100000 || result_out !== '0) begin
      errors++; $display("FAIL mid_reset_async: got flags=%b rdy=%b ov=%b res=%h expected 1000/0/0/0",
                         {idle, fetch, compute, write_back}, in_ready, out_valid, result_out);
    end
    #2 rst = 0;
    @(posedge clk); #1;
    test_basic();
  endtask

  initial begin
    rst = 1; start = 0; c_data_in = '0; in_valid = 0; out_ready = 0;
    a_data_in = '0; idx_in = '0; b_data_in = '0;
    @(posedge clk); #1;
    test_reset();
    @(posedge clk); #1;
    test_basic();
    test_signed_wrap();
    test_preload();
    test_back_to_back();
    test_backpressure();
    test_ignored_start();
    test_midop_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
